// File: rtl/mult_share_arbiter_pkg.sv
// mult_arb_pkg: shared widths, clog2 helper and tag pipeline entry type
package mult_arb_pkg;
  localparam int MAX_REQ = 8;
  localparam int MAX_ID_W = 3;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction
  typedef struct packed {
    logic                v;
    logic [MAX_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: requester, multiplier and result signals of the shared multiplier
interface mult_share_arbiter_if #(parameter int NUM_REQ = 4, parameter int DATA_W = 8);
  import mult_arb_pkg::*;
  localparam int ID_W = id_w(NUM_REQ);
  localparam int PROD_W = prod_w(DATA_W);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [DATA_W-1:0]         mul_a;
  logic [DATA_W-1:0]         mul_b;
  logic [PROD_W-1:0]         mul_p;
  logic [NUM_REQ-1:0]        res_valid;
  logic [PROD_W-1:0]         res_data;
  logic [ID_W-1:0]           res_id;
  logic                      idle;
  modport slave (
    input  req_valid, req_a, req_b, mul_p,
    output req_ready, mul_a, mul_b, res_valid, res_data, res_id, idle
  );
  modport master (
    output req_valid, req_a, req_b, mul_p,
    input  req_ready, mul_a, mul_b, res_valid, res_data, res_id, idle
  );
endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, search starts at ptr and wraps
module rr_arbiter import mult_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  logic [ID_W-1:0] j;
  // walk offsets from farthest to nearest so the nearest valid index wins
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one fixed-latency multiplier with tag-routed results
module mult_share_arbiter import mult_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int MULT_LAT = 3
) (
  input logic clk,
  input logic rst_n,
  mult_share_arbiter_if.slave bus
);
  localparam int ID_W = id_w(NUM_REQ);
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gidx;
  logic [ID_W-1:0]    ptr;
  logic               gany;
  logic               hs;
  logic               busy;
  tag_t               tag [MULT_LAT+1];
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req(bus.req_valid), .ptr(ptr), .grant(grant), .idx(gidx), .any(gany)
  );
  assign bus.req_ready = rst_n ? grant : '0;
  assign hs = rst_n & gany;
  always_comb begin
    busy = 1'b0;
    for (int s = 0; s <= MULT_LAT; s++) busy = busy | tag[s].v;
  end
  assign bus.idle = !hs && !busy;
  // last tag stage lines up with mul_p, so the product is captured with its owner id
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      bus.mul_a <= '0;
      bus.mul_b <= '0;
      for (int s = 0; s <= MULT_LAT; s++) tag[s] <= '0;
      bus.res_valid <= '0;
      bus.res_data <= '0;
      bus.res_id <= '0;
    end else begin
      if (hs) begin
        ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        bus.mul_a <= bus.req_a[gidx*DATA_W +: DATA_W];
        bus.mul_b <= bus.req_b[gidx*DATA_W +: DATA_W];
      end
      tag[0] <= '{v: hs, id: MAX_ID_W'(gidx)};
      for (int s = 1; s <= MULT_LAT; s++) tag[s] <= tag[s-1];
      bus.res_valid <= tag[MULT_LAT].v ? NUM_REQ'(1) << tag[MULT_LAT].id : '0;
      if (tag[MULT_LAT].v) begin
        bus.res_data <= bus.mul_p;
        bus.res_id <= tag[MULT_LAT].id[ID_W-1:0];
      end
    end
endmodule
